// File: rtl/key_event_sched.sv
// key_event_sched: turns raw PS/2 scan-code bytes into one event per key press.
// It strips break (F0 xx) and extended (E0 ...) sequences and suppresses typematic
// repeat. Accepted make codes are queued and handed out over a valid/ready handshake.
module key_event_sched #(
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int TIMEOUT = 50000,
  parameter int TW      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic [7:0] held_code,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  state_t        state, state_n;
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;
  logic [7:0]    held_n;
  logic          push_req;
  logic          ignored;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [AW:0]   count, count_n;
  logic          pop, full, push_ok, ovf_set;
  logic [7:0]    head_n;

  // Protocol bytes that never represent a key.
  always_comb begin
    ignored = (rx_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF});
  end

  // Parser: next state, make-code push request and held-key tracking.
  always_comb begin
    state_n  = state;
    held_n   = held_code;
    push_req = 1'b0;
    case (state)
      IDLE: begin
        if (rx_done_tick) begin
          if (rx_data == 8'hE0) begin
            state_n = EXT;
          end else if (rx_data == 8'hF0) begin
            state_n = BRK;
          end else if (!ignored && !(held_code != 8'h00 && rx_data == held_code)) begin
            push_req = 1'b1;
            held_n   = rx_data;
          end
        end
      end
      BRK: begin
        if (rx_done_tick) begin
          if (rx_data == held_code) held_n = 8'h00;
          state_n = IDLE;
        end else if (tmo_cnt == TO_LAST) begin
          state_n = IDLE;
        end
      end
      EXT: begin
        if (rx_done_tick) begin
          state_n = (rx_data == 8'hF0) ? EXT_BRK : IDLE;
        end else if (tmo_cnt == TO_LAST) begin
          state_n = IDLE;
        end
      end
      EXT_BRK: begin
        if (rx_done_tick || tmo_cnt == TO_LAST) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Every byte in a prefix state leaves that state, so the counter only
    // survives idle cycles; any state change (or IDLE) restarts it.
    tmo_cnt_n = (state_n == IDLE || state_n != state) ? '0 : tmo_cnt + 1'b1;
  end

  // FIFO bookkeeping and the registered head-of-queue value.
  always_comb begin
    pop      = key_valid && key_ready;
    full     = (count == FULL_CNT);
    push_ok  = push_req && (!full || pop);
    ovf_set  = push_req && full && !pop;
    wr_ptr_n = push_ok ? wr_ptr + 1'b1 : wr_ptr;
    rd_ptr_n = pop ? rd_ptr + 1'b1 : rd_ptr;
    count_n  = count;
    if (push_ok && !pop) count_n = count + 1'b1;
    if (!push_ok && pop) count_n = count - 1'b1;
    // The slot being written becomes the head only when the queue is
    // otherwise empty after this cycle's pop; bypass it so the output is
    // valid one cycle after the strobe.
    if (count_n == '0) begin
      head_n = 8'h00;
    end else if (push_ok && wr_ptr == rd_ptr_n) begin
      head_n = rx_data;
    end else begin
      head_n = mem[rd_ptr_n];
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      held_code <= 8'h00;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      key_valid <= 1'b0;
      key_code  <= 8'h00;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      tmo_cnt   <= tmo_cnt_n;
      held_code <= held_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      key_valid <= (count_n != '0);
      key_code  <= head_n;
      if (ovf_set) overflow <= 1'b1;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_data;
  end

endmodule

// File: tb/tb_key_event_sched.sv
// Directed self-checking bench for key_event_sched.
module tb_key_event_sched;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       key_ready = 1'b0;
  logic       key_valid;
  logic [7:0] key_code;
  logic [7:0] held_code;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  key_event_sched #(.DEPTH(4), .AW(2), .TIMEOUT(TMO), .TW(16)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .key_ready(key_ready), .key_valid(key_valid), .key_code(key_code),
    .held_code(held_code), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done_tick = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic pop_one();
    key_ready = 1'b1;
    @(posedge clk); #1;
    key_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    if (key_valid !== 1'b0) begin $display("FAIL reset_valid: got %b exp 0", key_valid); fails++; end
    tests++;
    if (key_code !== 8'h00) begin $display("FAIL reset_code: got %h exp 00", key_code); fails++; end
    tests++;
    if (held_code !== 8'h00) begin $display("FAIL reset_held: got %h exp 00", held_code); fails++; end
    tests++;
    if (overflow !== 1'b0) begin $display("FAIL reset_ovf: got %b exp 0", overflow); fails++; end
    tests++;
  endtask

  task automatic test_basic();
    send_byte(8'h24);
    if (key_valid !== 1'b1) begin $display("FAIL basic_valid: got %b exp 1", key_valid); fails++; end
    tests++;
    if (key_code !== 8'h24) begin $display("FAIL basic_code: got %h exp 24", key_code); fails++; end
    tests++;
    if (held_code !== 8'h24) begin $display("FAIL basic_held: got %h exp 24", held_code); fails++; end
    tests++;
    pop_one();
    if (key_valid !== 1'b0) begin $display("FAIL basic_pop_valid: got %b exp 0", key_valid); fails++; end
    tests++;
    if (key_code !== 8'h00) begin $display("FAIL basic_pop_code: got %h exp 00", key_code); fails++; end
    tests++;
  endtask

  task automatic test_typematic();
    send_byte(8'h16); send_byte(8'h16); send_byte(8'h16);
    send_byte(8'hF0); send_byte(8'h16);
    if (held_code !== 8'h00) begin $display("FAIL typ_break_held: got %h exp 00", held_code); fails++; end
    tests++;
    send_byte(8'h16);
    if (held_code !== 8'h16) begin $display("FAIL typ_held: got %h exp 16", held_code); fails++; end
    tests++;
    if (key_code !== 8'h16 || key_valid !== 1'b1) begin
      $display("FAIL typ_first: got %b/%h exp 1/16", key_valid, key_code); fails++;
    end
    tests++;
    pop_one();
    if (key_code !== 8'h16 || key_valid !== 1'b1) begin
      $display("FAIL typ_second: got %b/%h exp 1/16", key_valid, key_code); fails++;
    end
    tests++;
    pop_one();
    if (key_valid !== 1'b0) begin $display("FAIL typ_empty: got %b exp 0", key_valid); fails++; end
    tests++;
  endtask

  task automatic test_extended();
    send_byte(8'hE0); send_byte(8'h75);
    if (key_valid !== 1'b0) begin $display("FAIL ext_make_dropped: got %b exp 0", key_valid); fails++; end
    tests++;
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    if (key_valid !== 1'b0) begin $display("FAIL ext_brk_dropped: got %b exp 0", key_valid); fails++; end
    tests++;
    if (held_code !== 8'h16) begin $display("FAIL ext_held_kept: got %h exp 16", held_code); fails++; end
    tests++;
    send_byte(8'h1C);
    if (key_code !== 8'h1C || key_valid !== 1'b1) begin
      $display("FAIL ext_after: got %b/%h exp 1/1c", key_valid, key_code); fails++;
    end
    tests++;
    pop_one();
    if (key_valid !== 1'b0) begin $display("FAIL ext_empty: got %b exp 0", key_valid); fails++; end
    tests++;
  endtask

  task automatic test_timeout();
    // Full timeout elapses: the next byte is a fresh make.
    send_byte(8'hF0);
    repeat (TMO) @(posedge clk); #1;
    send_byte(8'h45);
    if (key_code !== 8'h45 || key_valid !== 1'b1) begin
      $display("FAIL tmo_make: got %b/%h exp 1/45", key_valid, key_code); fails++;
    end
    tests++;
    if (held_code !== 8'h45) begin $display("FAIL tmo_held: got %h exp 45", held_code); fails++; end
    tests++;
    pop_one();
    // One cycle short of the timeout: the byte still ends the break.
    send_byte(8'hF0);
    repeat (TMO - 1) @(posedge clk); #1;
    send_byte(8'h45);
    if (key_valid !== 1'b0) begin $display("FAIL tmo_edge_valid: got %b exp 0", key_valid); fails++; end
    tests++;
    if (held_code !== 8'h00) begin $display("FAIL tmo_edge_held: got %h exp 00", held_code); fails++; end
    tests++;
  endtask

  task automatic test_overflow();
    logic [7:0] seq [13];
    logic [7:0] exp_q [4];
    seq = '{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'h26, 8'hF0, 8'h26,
            8'h25, 8'hF0, 8'h25, 8'h2E};
    exp_q = '{8'h1E, 8'h26, 8'h25, 8'h36};
    foreach (seq[i]) send_byte(seq[i]);
    if (overflow !== 1'b1) begin $display("FAIL ovf_set: got %b exp 1", overflow); fails++; end
    tests++;
    if (key_code !== 8'h16 || key_valid !== 1'b1) begin
      $display("FAIL ovf_head: got %b/%h exp 1/16", key_valid, key_code); fails++;
    end
    tests++;
    send_byte(8'hF0); send_byte(8'h2E);
    // Pop and push in the same cycle while full.
    rx_data = 8'h36;
    rx_done_tick = 1'b1;
    key_ready = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    key_ready = 1'b0;
    if (overflow !== 1'b1) begin $display("FAIL ovf_sticky: got %b exp 1", overflow); fails++; end
    tests++;
    for (int i = 0; i < 4; i++) begin
      if (key_code !== exp_q[i] || key_valid !== 1'b1) begin
        $display("FAIL ovf_drain%0d: got %b/%h exp 1/%h", i, key_valid, key_code, exp_q[i]); fails++;
      end
      tests++;
      pop_one();
    end
    if (key_valid !== 1'b0) begin $display("FAIL ovf_empty: got %b exp 0", key_valid); fails++; end
    tests++;
  endtask

  task automatic test_reset_midseq();
    send_byte(8'h1D); send_byte(8'h24); send_byte(8'h2D);
    send_byte(8'hF0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    if (key_valid !== 1'b0) begin $display("FAIL rst_mid_valid: got %b exp 0", key_valid); fails++; end
    tests++;
    if (held_code !== 8'h00) begin $display("FAIL rst_mid_held: got %h exp 00", held_code); fails++; end
    tests++;
    if (overflow !== 1'b0) begin $display("FAIL rst_mid_ovf: got %b exp 0", overflow); fails++; end
    tests++;
    send_byte(8'h1B);
    if (key_code !== 8'h1B || key_valid !== 1'b1) begin
      $display("FAIL rst_mid_make: got %b/%h exp 1/1b", key_valid, key_code); fails++;
    end
    tests++;
    if (held_code !== 8'h1B) begin $display("FAIL rst_mid_held2: got %h exp 1b", held_code); fails++; end
    tests++;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_typematic();
    test_extended();
    test_timeout();
    test_overflow();
    test_reset_midseq();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
